lfu_freq_scheduler: RTL and testbench
=====================================

Name: lfu_freq_scheduler

Overview:
Owns the per-line use-frequency counters of the LFU cache and sequences every operation on them. It arbitrates between hit increments, line allocation, a periodic aging sweep and victim-search requests. Aging is paced by the 1-cycle tick pulse from the existing half-second timer: every AGE_PERIOD ticks, all counters are halved so stale popularity decays. The victim search returns the least-frequently-used line to the replacement logic.

Parameters:
LINES, 8, number of cache lines / counters (power of 2, >=2)
CNT_W, 8, width of each frequency counter
AGE_PERIOD, 4, ticks between aging sweeps (>=1)

Ports:
clock  in  1  system clock
rst  in  1  synchronous, active-high reset
tick  in  1  1-cycle pulse from the timer
hit_valid  in  1  cache hit on hit_idx this cycle
hit_idx  in  $clog2(LINES)  line that hit
alloc_valid  in  1  line alloc_idx (re)filled this cycle
alloc_idx  in  $clog2(LINES)  line being allocated
victim_req  in  1  request LFU victim search (level, sampled in IDLE)
busy  out  1  FSM not IDLE
age_active  out  1  aging sweep in progress
victim_valid  out  1  1-cycle pulse: victim_idx valid
victim_idx  out  $clog2(LINES)  selected victim line (held until next result)
rd_idx  in  $clog2(LINES)  debug read select
rd_cnt  out  CNT_W  combinational counter value at rd_idx

Behaviour:
- Reset: all counters 0, FSM IDLE, tick prescaler 0, age_pending 0, busy 0, age_active 0, victim_valid 0, victim_idx 0. Reset mid-scan or mid-sweep aborts it; no victim_valid is emitted.
- Counter updates are applied in every state, with the following rules:
  - hit: cnt <= cnt+1, saturating at 2^CNT_W-1.
  - alloc: cnt <= 1.
  - Hit and alloc on different indices in the same cycle: both apply.
  - Hit and alloc on the same index: alloc wins, result 1.
- Prescaler: counts tick pulses 0..AGE_PERIOD-1. The tick that arrives at count AGE_PERIOD-1 wraps the count to 0 and sets age_pending. This also happens during a sweep, so at most one sweep is queued.
- FSM states are IDLE, SCAN and AGE.
  - IDLE to SCAN: victim_req=1. victim_req takes priority over age_pending when both are present.
  - IDLE to AGE: age_pending=1 and victim_req=0. age_pending clears on entry. The sweep pointer p is set to 0.
  - SCAN: one line per cycle, with scan index s=0..LINES-1. Keep min_val/min_idx. On entry min_val = cnt[0] and min_idx = 0. A line replaces the current minimum only if it is strictly lower, so ties go to the lowest index. The scan reads the live counter values, so an update in the same cycle is not seen until the next cycle.
  - SCAN latency: victim_req sampled in cycle 0 -> lines 0..LINES-1 compared in cycles 1..LINES -> victim_valid=1 with victim_idx in cycle LINES+1 -> back to IDLE in the same cycle. victim_req held high re-triggers a scan from cycle LINES+2.
  - AGE, each cycle: if hit_valid or alloc_valid is asserted, the step stalls (p unchanged, no halving). Otherwise cnt[p] <= cnt[p]>>1 and p++.
  - AGE exit: after the step at p=LINES-1 the FSM returns to IDLE. A sweep therefore lasts LINES cycles plus the number of stall cycles. victim_req during AGE waits until IDLE.
- age_active=1 exactly while in AGE; busy=1 in SCAN or AGE.
- All arithmetic is unsigned. The pointer and scan index are $clog2(LINES) bits and never wrap mid-operation.

Decomposition:
- Package lfu_pkg: state enum (IDLE, SCAN, AGE), and the localparams IDX_W=$clog2(LINES) and CNT_MAX.
- One sub-module, lfu_tick_prescaler: tick counter producing the age_pending request. It has rst, tick and a clear input driven on AGE entry.

Test Plan (LINES=4, CNT_W=4, AGE_PERIOD=2):
1. Reset, then victim_req in cycle 0 -> busy=1 in cycles 1..4, victim_valid pulse in cycle 5 with victim_idx=0, busy=0 in cycle 5.
2. Hits on line0 x3, line1 x1, line2 x2, alloc line3 -> rd_cnt reads 3,1,2,1; victim_req -> victim_idx=1 (tie with line3 resolved to the lower index).
3. 20 consecutive hits on line2 -> rd_cnt[2]=15 (saturated); simultaneous hit and alloc on line1 -> rd_cnt[1]=1.
4. Counters 8,4,2,1, then two tick pulses -> age_active rises the cycle after the second tick, stays 4 cycles; counters become 4,2,1,0.
5. Same start as 4 with hit_valid on line1 during the 2nd sweep cycle -> sweep lasts 5 cycles, line1 ends (4+1)>>1=2. Simultaneous victim_req and age_pending in IDLE -> scan first, sweep starts immediately after victim_valid.
6. rst asserted in cycle 2 of a scan -> busy=0 next cycle, no victim_valid, all rd_cnt=0.

Source files
------------

// File: rtl/lfu_freq_scheduler_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package     : lfu_pkg                                                  |
// | Description : Shared state encoding, sizing helpers and default        |
// |               configuration constants for the LFU frequency scheduler. |
// | Ports       : none                                                     |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
package lfu_pkg;

  // Scheduler FSM encoding.
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t SCAN = 2'd1;
  localparam state_t AGE  = 2'd2;

  // Index width for a given line count. Never returns 0, so a one-bit
  // index still exists for degenerate configurations.
  function automatic int idx_w(input int lines);
    return (lines > 1) ? $clog2(lines) : 1;
  endfunction

  // Largest value a counter of the given width can hold.
  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction

  // Default configuration.
  localparam int DEF_LINES = 8;
  localparam int DEF_CNT_W = 8;
  localparam int IDX_W     = idx_w(DEF_LINES);
  localparam int CNT_MAX   = cnt_max(DEF_CNT_W);

endpackage
`default_nettype wire

// File: rtl/lfu_freq_scheduler_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Interface   : lfu_freq_scheduler_if                                    |
// | Description : Bundle of all scheduler signals except clock and reset.  |
// |   master drives: tick, hit_valid/hit_idx, alloc_valid/alloc_idx,       |
// |                  victim_req, rd_idx                                    |
// |   slave drives : busy, age_active, victim_valid/victim_idx, rd_cnt     |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
interface lfu_freq_scheduler_if
  import lfu_pkg::*;
#(
  parameter int LINES = DEF_LINES,
  parameter int CNT_W = DEF_CNT_W
);
  localparam int IW = idx_w(LINES);

  logic             tick;
  logic             hit_valid;
  logic [IW-1:0]    hit_idx;
  logic             alloc_valid;
  logic [IW-1:0]    alloc_idx;
  logic             victim_req;
  logic             busy;
  logic             age_active;
  logic             victim_valid;
  logic [IW-1:0]    victim_idx;
  logic [IW-1:0]    rd_idx;
  logic [CNT_W-1:0] rd_cnt;

  modport master (
    output tick, hit_valid, hit_idx, alloc_valid, alloc_idx, victim_req, rd_idx,
    input  busy, age_active, victim_valid, victim_idx, rd_cnt
  );

  modport slave (
    input  tick, hit_valid, hit_idx, alloc_valid, alloc_idx, victim_req, rd_idx,
    output busy, age_active, victim_valid, victim_idx, rd_cnt
  );

endinterface
`default_nettype wire

// File: rtl/lfu_tick_prescaler.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : lfu_tick_prescaler                                       |
// | Description : Counts timer ticks and raises an aging request every     |
// |               AGE_PERIOD ticks. At most one request is held.           |
// | Ports       : clock, rst  - clock / synchronous active-high reset      |
// |               tick        - 1-cycle timer pulse                        |
// |               clear       - request consumed (sweep starting)          |
// |               age_pending - request outstanding                        |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module lfu_tick_prescaler #(
  parameter int AGE_PERIOD = 4
) (
  input  wire logic clock,
  input  wire logic rst,
  input  wire logic tick,
  input  wire logic clear,
  output logic      age_pending
);
  localparam int            CW   = (AGE_PERIOD > 1) ? $clog2(AGE_PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(AGE_PERIOD - 1);

  logic [CW-1:0] count_q, count_d;
  logic          pending_q, pending_d;
  logic          wrap;

  always_comb begin
    wrap    = tick && (count_q == LAST);
    count_d = count_q;
    if (tick) begin
      count_d = wrap ? '0 : count_q + 1'b1;
    end
    // The wrapping tick is visible to the FSM in the same cycle, so a
    // clear in that cycle consumes it as well as any stored request.
    pending_d = clear ? 1'b0 : (pending_q | wrap);
  end

  assign age_pending = pending_q | wrap;

  always_ff @(posedge clock) begin
    if (rst) begin
      count_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      pending_q <= pending_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/lfu_freq_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : lfu_freq_scheduler                                       |
// | Description : Per-line LFU use counters with hit/alloc updates, a      |
// |               tick-paced halving sweep and a linear victim search.     |
// | Ports       : clock, rst - clock / synchronous active-high reset       |
// |               bus (slave) - tick, hit, alloc, victim request/result,   |
// |                             busy/age_active status, debug read port    |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module lfu_freq_scheduler
  import lfu_pkg::*;
#(
  parameter int LINES      = 8,
  parameter int CNT_W      = 8,
  parameter int AGE_PERIOD = 4
) (
  input  wire logic            clock,
  input  wire logic            rst,
  lfu_freq_scheduler_if.slave  bus
);
  localparam int               IW       = idx_w(LINES);
  localparam logic [IW-1:0]    LAST_IDX = IW'(LINES - 1);
  localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(cnt_max(CNT_W));

  logic [CNT_W-1:0] cnt_q [LINES];
  logic [CNT_W-1:0] cnt_d [LINES];
  state_t           state_q, state_d;
  logic [IW-1:0]    s_q, s_d;
  logic [IW-1:0]    p_q, p_d;
  logic [CNT_W-1:0] min_val_q, min_val_d;
  logic [IW-1:0]    min_idx_q, min_idx_d;
  logic             victim_valid_q, victim_valid_d;
  logic [IW-1:0]    victim_idx_q, victim_idx_d;
  logic             age_pending;
  logic             age_clear;
  logic             age_step;
  logic [CNT_W-1:0] cur;

  lfu_tick_prescaler #(
    .AGE_PERIOD (AGE_PERIOD)
  ) u_prescaler (
    .clock       (clock),
    .rst         (rst),
    .tick        (bus.tick),
    .clear       (age_clear),
    .age_pending (age_pending)
  );

  always_comb begin
    state_d        = state_q;
    s_d            = s_q;
    p_d            = p_q;
    min_val_d      = min_val_q;
    min_idx_d      = min_idx_q;
    victim_valid_d = 1'b0;
    victim_idx_d   = victim_idx_q;
    age_clear      = 1'b0;
    age_step       = 1'b0;
    cur            = cnt_q[s_q];
    cnt_d          = cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.victim_req) begin
          state_d = SCAN;
          s_d     = '0;
        end else if (age_pending) begin
          state_d   = AGE;
          p_d       = '0;
          age_clear = 1'b1;
        end
      end
      SCAN: begin
        // Line 0 seeds the minimum; strict compare keeps the lowest index on ties.
        if ((s_q == '0) || (cur < min_val_q)) begin
          min_val_d = cur;
          min_idx_d = s_q;
        end
        if (s_q == LAST_IDX) begin
          state_d        = IDLE;
          victim_valid_d = 1'b1;
          victim_idx_d   = min_idx_d;
        end else begin
          s_d = s_q + 1'b1;
        end
      end
      AGE: begin
        // Any counter update this cycle stalls the sweep, so halving never
        // collides with a hit or alloc.
        if (!(bus.hit_valid || bus.alloc_valid)) begin
          age_step = 1'b1;
          p_d      = p_q + 1'b1;
          if (p_q == LAST_IDX) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (age_step) begin
      cnt_d[p_q] = cnt_q[p_q] >> 1;
    end
    if (bus.hit_valid && (cnt_q[bus.hit_idx] != CNT_TOP)) begin
      cnt_d[bus.hit_idx] = cnt_q[bus.hit_idx] + 1'b1;
    end
    // Applied last so alloc overrides a hit on the same line.
    if (bus.alloc_valid) begin
      cnt_d[bus.alloc_idx] = CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      cnt_q          <= '{default: '0};
      state_q        <= IDLE;
      s_q            <= '0;
      p_q            <= '0;
      min_val_q      <= '0;
      min_idx_q      <= '0;
      victim_valid_q <= 1'b0;
      victim_idx_q   <= '0;
    end else begin
      cnt_q          <= cnt_d;
      state_q        <= state_d;
      s_q            <= s_d;
      p_q            <= p_d;
      min_val_q      <= min_val_d;
      min_idx_q      <= min_idx_d;
      victim_valid_q <= victim_valid_d;
      victim_idx_q   <= victim_idx_d;
    end
  end

  assign bus.busy         = (state_q != IDLE);
  assign bus.age_active   = (state_q == AGE);
  assign bus.victim_valid = victim_valid_q;
  assign bus.victim_idx   = victim_idx_q;
  assign bus.rd_cnt       = cnt_q[bus.rd_idx];

endmodule
`default_nettype wire

// File: tb/tb_lfu_freq_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_lfu_freq_scheduler                                    |
// | Description : Self-checking bench for lfu_freq_scheduler with a        |
// |               counter model and a victim-result scoreboard.            |
// | Ports       : none                                                     |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_lfu_freq_scheduler;
  localparam int LINES      = 4;
  localparam int CNT_W      = 4;
  localparam int AGE_PERIOD = 2;
  localparam int IW         = 2;
  localparam int CMAX       = 15;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  always #5 clock = ~clock;

  lfu_freq_scheduler_if #(.LINES(LINES), .CNT_W(CNT_W)) bus ();

  lfu_freq_scheduler #(
    .LINES      (LINES),
    .CNT_W      (CNT_W),
    .AGE_PERIOD (AGE_PERIOD)
  ) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus.slave)
  );

  int vectors     = 0;
  int miscompares = 0;
  int pulses      = 0;
  int m [LINES];
  int exp_q [$];
  int got_q [$];

  // Advance one cycle; outputs are observed 1 time unit after the edge and
  // any victim result is captured for the scoreboard.
  task automatic cycle();
    @(posedge clock);
    #1;
    if (bus.victim_valid === 1'b1) begin
      got_q.push_back(int'(bus.victim_idx));
      pulses++;
    end
  endtask

  task automatic hit(input int i, input int n);
    repeat (n) begin
      bus.hit_valid = 1'b1;
      bus.hit_idx   = IW'(i);
      cycle();
      if (m[i] < CMAX) m[i]++;
    end
    bus.hit_valid = 1'b0;
  endtask

  task automatic alloc(input int i);
    bus.alloc_valid = 1'b1;
    bus.alloc_idx   = IW'(i);
    cycle();
    m[i] = 1;
    bus.alloc_valid = 1'b0;
  endtask

  task automatic set_count(input int i, input int v);
    alloc(i);
    hit(i, v - 1);
  endtask

  function automatic int model_victim();
    int best = 0;
    for (int i = 1; i < LINES; i++) if (m[i] < m[best]) best = i;
    return best;
  endfunction

  task automatic test_reset();
    bus.tick = 0; bus.hit_valid = 0; bus.hit_idx = '0; bus.alloc_valid = 0;
    bus.alloc_idx = '0; bus.victim_req = 0; bus.rd_idx = '0;
    rst = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
    for (int i = 0; i < LINES; i++) m[i] = 0;
    vectors++;
    if (bus.busy !== 1'b0 || bus.age_active !== 1'b0 || bus.victim_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_status: got busy=%b age=%b vv=%b expected 0 0 0",
               bus.busy, bus.age_active, bus.victim_valid);
    end
    vectors++;
    if (bus.victim_idx !== '0) begin
      miscompares++;
      $display("FAIL reset_victim_idx: got %0d expected 0", bus.victim_idx);
    end
    for (int i = 0; i < LINES; i++) begin
      bus.rd_idx = IW'(i); #1;
      vectors++;
      if (bus.rd_cnt !== CNT_W'(0)) begin
        miscompares++;
        $display("FAIL reset_cnt[%0d]: got %0d expected 0", i, bus.rd_cnt);
      end
    end
  endtask

  task automatic test_scan_latency();
    bus.victim_req = 1'b1;
    exp_q.push_back(model_victim());
    cycle();
    bus.victim_req = 1'b0;
    for (int k = 1; k <= LINES; k++) begin
      vectors++;
      if (bus.busy !== 1'b1 || bus.victim_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL scan_cycle%0d: got busy=%b vv=%b expected 1 0", k, bus.busy, bus.victim_valid);
      end
      cycle();
    end
    vectors++;
    if (bus.victim_valid !== 1'b1 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL scan_result_cycle: got vv=%b busy=%b expected 1 0", bus.victim_valid, bus.busy);
    end
    vectors++;
    if (got_q.size() == 0) begin
      miscompares++;
      $display("FAIL scan_victim: got no result expected %0d", exp_q[0]);
      exp_q.delete();
    end else begin
      int g = got_q.pop_front();
      int e = exp_q.pop_front();
      if (g !== e) begin
        miscompares++;
        $display("FAIL scan_victim: got %0d expected %0d", g, e);
      end
    end
  endtask

  task automatic test_hits_victim();
    int n;
    hit(0, 3); hit(1, 1); hit(2, 2); alloc(3);
    for (int i = 0; i < LINES; i++) begin
      bus.rd_idx = IW'(i); #1;
      vectors++;
      if (bus.rd_cnt !== CNT_W'(m[i])) begin
        miscompares++;
        $display("FAIL hits_cnt[%0d]: got %0d expected %0d", i, bus.rd_cnt, m[i]);
      end
    end
    bus.victim_req = 1'b1;
    exp_q.push_back(model_victim());
    cycle();
    bus.victim_req = 1'b0;
    n = 0;
    while (got_q.size() == 0 && n < 20) begin cycle(); n++; end
    vectors++;
    if (got_q.size() == 0) begin
      miscompares++;
      $display("FAIL tie_victim: got timeout expected %0d", exp_q[0]);
      exp_q.delete();
    end else begin
      int g = got_q.pop_front();
      int e = exp_q.pop_front();
      if (g !== e) begin
        miscompares++;
        $display("FAIL tie_victim: got %0d expected %0d", g, e);
      end
    end
  endtask

  task automatic test_saturation();
    hit(2, 20);
    bus.rd_idx = IW'(2); #1;
    vectors++;
    if (bus.rd_cnt !== CNT_W'(m[2])) begin
      miscompares++;
      $display("FAIL saturate: got %0d expected %0d", bus.rd_cnt, m[2]);
    end
    // Same-index hit and alloc: alloc wins.
    bus.hit_valid = 1'b1; bus.hit_idx = IW'(1);
    bus.alloc_valid = 1'b1; bus.alloc_idx = IW'(1);
    cycle();
    m[1] = 1;
    // Different-index hit and alloc: both apply.
    bus.hit_idx = IW'(0); bus.alloc_idx = IW'(3);
    cycle();
    m[0] = (m[0] < CMAX) ? m[0] + 1 : CMAX; m[3] = 1;
    bus.hit_valid = 1'b0; bus.alloc_valid = 1'b0;
    for (int i = 0; i < LINES; i++) begin
      bus.rd_idx = IW'(i); #1;
      vectors++;
      if (bus.rd_cnt !== CNT_W'(m[i])) begin
        miscompares++;
        $display("FAIL hit_alloc_cnt[%0d]: got %0d expected %0d", i, bus.rd_cnt, m[i]);
      end
    end
  endtask

  task automatic test_aging();
    int n;
    set_count(0, 8); set_count(1, 4); set_count(2, 2); set_count(3, 1);
    bus.tick = 1'b1; cycle(); bus.tick = 1'b0;
    vectors++;
    if (bus.age_active !== 1'b0) begin
      miscompares++;
      $display("FAIL age_early: got %b expected 0", bus.age_active);
    end
    cycle();
    bus.tick = 1'b1; cycle(); bus.tick = 1'b0;
    vectors++;
    if (bus.age_active !== 1'b1) begin
      miscompares++;
      $display("FAIL age_start: got %b expected 1", bus.age_active);
    end
    n = 0;
    while (bus.age_active === 1'b1 && n < 20) begin n++; cycle(); end
    vectors++;
    if (n !== LINES) begin
      miscompares++;
      $display("FAIL age_length: got %0d expected %0d", n, LINES);
    end
    for (int i = 0; i < LINES; i++) m[i] = m[i] >> 1;
    for (int i = 0; i < LINES; i++) begin
      bus.rd_idx = IW'(i); #1;
      vectors++;
      if (bus.rd_cnt !== CNT_W'(m[i])) begin
        miscompares++;
        $display("FAIL aged_cnt[%0d]: got %0d expected %0d", i, bus.rd_cnt, m[i]);
      end
    end
  endtask

  task automatic test_stall_and_priority();
    int n;
    set_count(0, 8); set_count(1, 4); set_count(2, 2); set_count(3, 1);
    bus.tick = 1'b1; cycle(); bus.tick = 1'b0; cycle();
    bus.tick = 1'b1; cycle(); bus.tick = 1'b0;
    n = (bus.age_active === 1'b1) ? 1 : 0;
    cycle();                                  // second sweep cycle
    bus.hit_valid = 1'b1; bus.hit_idx = IW'(1);
    if (bus.age_active === 1'b1) n++;
    cycle();
    bus.hit_valid = 1'b0;
    m[1] = m[1] + 1;
    while (bus.age_active === 1'b1 && n < 20) begin n++; cycle(); end
    vectors++;
    if (n !== LINES + 1) begin
      miscompares++;
      $display("FAIL stall_length: got %0d expected %0d", n, LINES + 1);
    end
    for (int i = 0; i < LINES; i++) m[i] = m[i] >> 1;
    for (int i = 0; i < LINES; i++) begin
      bus.rd_idx = IW'(i); #1;
      vectors++;
      if (bus.rd_cnt !== CNT_W'(m[i])) begin
        miscompares++;
        $display("FAIL stall_cnt[%0d]: got %0d expected %0d", i, bus.rd_cnt, m[i]);
      end
    end
    // Victim request and aging request together in IDLE.
    bus.tick = 1'b1; cycle(); bus.tick = 1'b0; cycle();
    bus.tick = 1'b1; bus.victim_req = 1'b1;
    exp_q.push_back(model_victim());
    cycle();
    bus.tick = 1'b0; bus.victim_req = 1'b0;
    for (int k = 1; k <= LINES; k++) begin
      vectors++;
      if (bus.busy !== 1'b1 || bus.age_active !== 1'b0) begin
        miscompares++;
        $display("FAIL prio_scan%0d: got busy=%b age=%b expected 1 0", k, bus.busy, bus.age_active);
      end
      cycle();
    end
    vectors++;
    if (bus.victim_valid !== 1'b1 || bus.age_active !== 1'b0) begin
      miscompares++;
      $display("FAIL prio_result: got vv=%b age=%b expected 1 0", bus.victim_valid, bus.age_active);
    end
    cycle();
    vectors++;
    if (bus.age_active !== 1'b1) begin
      miscompares++;
      $display("FAIL prio_age_follow: got %b expected 1", bus.age_active);
    end
    vectors++;
    if (got_q.size() == 0) begin
      miscompares++;
      $display("FAIL prio_victim: got no result expected %0d", exp_q[0]);
      exp_q.delete();
    end else begin
      int g = got_q.pop_front();
      int e = exp_q.pop_front();
      if (g !== e) begin
        miscompares++;
        $display("FAIL prio_victim: got %0d expected %0d", g, e);
      end
    end
    n = 0;
    while (bus.age_active === 1'b1 && n < 20) begin n++; cycle(); end
    for (int i = 0; i < LINES; i++) m[i] = m[i] >> 1;
    for (int i = 0; i < LINES; i++) begin
      bus.rd_idx = IW'(i); #1;
      vectors++;
      if (bus.rd_cnt !== CNT_W'(m[i])) begin
        miscompares++;
        $display("FAIL prio_aged_cnt[%0d]: got %0d expected %0d", i, bus.rd_cnt, m[i]);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    int p0;
    hit(2, 3);
    bus.victim_req = 1'b1;
    cycle();
    bus.victim_req = 1'b0;
    cycle();
    rst = 1'b1;                               // scan cycle 2
    cycle();
    rst = 1'b0;
    for (int i = 0; i < LINES; i++) m[i] = 0;
    p0 = pulses;
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_busy: got %b expected 0", bus.busy);
    end
    repeat (2 * LINES) cycle();
    vectors++;
    if (pulses !== p0 || got_q.size() != 0) begin
      miscompares++;
      $display("FAIL abort_no_victim: got %0d pulses expected 0", pulses - p0);
    end
    for (int i = 0; i < LINES; i++) begin
      bus.rd_idx = IW'(i); #1;
      vectors++;
      if (bus.rd_cnt !== CNT_W'(m[i])) begin
        miscompares++;
        $display("FAIL abort_cnt[%0d]: got %0d expected 0", i, bus.rd_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan_latency();
    test_hits_victim();
    test_saturation();
    test_aging();
    test_stall_and_priority();
    test_reset_mid_scan();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
